// File: rtl/pwm_duty_scheduler_pkg.sv
// Shared definitions for the PWM duty scheduler: FSM encoding, underrun counter
// sizing and the midscale duty derivation.
package pwm_duty_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } sched_state_e;

  localparam int UNDERRUN_CNT_W = 8;
  localparam logic [UNDERRUN_CNT_W-1:0] UNDERRUN_CNT_MAX = '1;

  // Offset-binary zero for a duty word of the given width.
  function automatic logic [31:0] midscale_of(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pwm_duty_scheduler_fifo.sv
// Synchronous sample FIFO with flush; pop data is the current head (show-ahead).
module pwm_sample_fifo #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == DEPTH_L);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign level    = count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Feeds one offset-binary duty word per PWM period from a sample FIFO, with
// static override, FIFO priming and underrun reporting.
//
// state    | meaning
// ST_IDLE  | counter held at 0, FIFO flushed, duty at midscale, no intake
// ST_PRIME | accepting samples, counter held, waiting for enough FIFO level
// ST_RUN   | period counter free-runs; duty updated at each boundary
module pwm_duty_scheduler
  import pwm_duty_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int COUNTER_WIDTH = 10,
  parameter int FIFO_DEPTH    = 4,
  parameter int PRIME_LEVEL   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          Enable,
  input  logic [DATA_WIDTH-1:0]         SampleIn,
  input  logic                          SampleValid,
  output logic                          SampleReady,
  input  logic                          OverrideEn,
  input  logic [DATA_WIDTH-1:0]         OverrideDuty,
  input  logic                          HoldLast,
  output logic [DATA_WIDTH-1:0]         DutyOut,
  output logic                          PeriodStart,
  output logic                          Underrun,
  output logic [UNDERRUN_CNT_W-1:0]     UnderrunCount,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0]    MIDSCALE  = DATA_WIDTH'(midscale_of(DATA_WIDTH));
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [LEVEL_W-1:0]       PRIME_LVL = LEVEL_W'(PRIME_LEVEL);

  sched_state_e                state;
  sched_state_e                state_nxt;
  logic [COUNTER_WIDTH-1:0]    counter;
  logic [COUNTER_WIDTH-1:0]    counter_nxt;
  logic [DATA_WIDTH-1:0]       duty_q;
  logic [DATA_WIDTH-1:0]       duty_nxt;
  logic                        period_start_q;
  logic                        underrun_q;
  logic                        underrun_nxt;
  logic [UNDERRUN_CNT_W-1:0]   underrun_cnt_q;
  logic [UNDERRUN_CNT_W-1:0]   underrun_cnt_nxt;

  logic                        boundary;
  logic                        push;
  logic                        pop;
  logic                        flush;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [DATA_WIDTH-1:0]       fifo_data;
  logic [LEVEL_W-1:0]          fifo_level;

  assign boundary    = (state == ST_RUN) && (counter == CNT_MAX);
  assign SampleReady = (state != ST_IDLE) && !fifo_full;
  assign push        = SampleValid && SampleReady;
  assign pop         = boundary && !OverrideEn && !fifo_empty;
  // Dropping Enable empties the FIFO on the same edge that enters IDLE.
  assign flush       = (state == ST_IDLE) || !Enable;

  pwm_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (SampleIn),
    .pop       (pop),
    .pop_data  (fifo_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (Enable) state_nxt = ST_PRIME;
      ST_PRIME: begin
        if (!Enable)                                    state_nxt = ST_IDLE;
        else if ((fifo_level >= PRIME_LVL) || OverrideEn) state_nxt = ST_RUN;
      end
      ST_RUN:   if (!Enable) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Boundary update wins over the Enable-drop midscale so the last word lands.
  always_comb begin
    counter_nxt      = (state == ST_RUN && Enable) ? counter + 1'b1 : '0;
    duty_nxt         = duty_q;
    underrun_nxt     = 1'b0;
    underrun_cnt_nxt = underrun_cnt_q;
    if (boundary) begin
      if (OverrideEn) begin
        duty_nxt = OverrideDuty;
      end else if (!fifo_empty) begin
        duty_nxt = {~fifo_data[DATA_WIDTH-1], fifo_data[DATA_WIDTH-2:0]};
      end else begin
        underrun_nxt = 1'b1;
        if (underrun_cnt_q != UNDERRUN_CNT_MAX) underrun_cnt_nxt = underrun_cnt_q + 1'b1;
        if (!HoldLast) duty_nxt = MIDSCALE;
      end
    end else if (state != ST_RUN || !Enable) begin
      duty_nxt = MIDSCALE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter        <= '0;
      duty_q         <= MIDSCALE;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      counter        <= counter_nxt;
      duty_q         <= duty_nxt;
      period_start_q <= boundary;
      underrun_q     <= underrun_nxt;
      underrun_cnt_q <= underrun_cnt_nxt;
    end
  end

  assign DutyOut       = duty_q;
  assign PeriodStart   = period_start_q;
  assign Underrun      = underrun_q;
  assign UnderrunCount = underrun_cnt_q;
  assign FifoLevel     = fifo_level;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Scoreboard bench for pwm_duty_scheduler with a queue-based reference model.
module tb_pwm_duty_scheduler;

  localparam int DW = 10;
  localparam int CW = 4;
  localparam int FD = 4;
  localparam int PL = 2;
  localparam int PERIOD = 16;
  localparam logic [DW-1:0] MID = 10'h200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          Enable = 1'b0;
  logic [DW-1:0] SampleIn = '0;
  logic          SampleValid = 1'b0;
  logic          SampleReady;
  logic          OverrideEn = 1'b0;
  logic [DW-1:0] OverrideDuty = '0;
  logic          HoldLast = 1'b0;
  logic [DW-1:0] DutyOut;
  logic          PeriodStart;
  logic          Underrun;
  logic [7:0]    UnderrunCount;
  logic [2:0]    FifoLevel;

  pwm_duty_scheduler #(
    .DATA_WIDTH    (DW),
    .COUNTER_WIDTH (CW),
    .FIFO_DEPTH    (FD),
    .PRIME_LEVEL   (PL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Enable        (Enable),
    .SampleIn      (SampleIn),
    .SampleValid   (SampleValid),
    .SampleReady   (SampleReady),
    .OverrideEn    (OverrideEn),
    .OverrideDuty  (OverrideDuty),
    .HoldLast      (HoldLast),
    .DutyOut       (DutyOut),
    .PeriodStart   (PeriodStart),
    .Underrun      (Underrun),
    .UnderrunCount (UnderrunCount),
    .FifoLevel     (FifoLevel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 priming, 2 running; m_cnt = cycles into period.
  logic [DW-1:0] src_q[$];
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] m_q[$];
  int            m_st = 0;
  int            m_cnt = 0;
  int            m_ucnt = 0;
  logic [DW-1:0] m_duty = MID;
  bit            m_ps = 1'b0;
  bit            m_ur = 1'b0;
  int            valid_pct = 100;
  logic [DW:0]   sb_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic drive();
    SampleValid = (src_q.size() != 0) && ($urandom_range(99) < 32'(valid_pct));
    SampleIn    = (src_q.size() != 0) ? src_q[0] : 10'($urandom);
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_st = 0; m_cnt = 0; m_ucnt = 0; m_duty = MID; m_ps = 0; m_ur = 0;
  endtask

  // One clock: check outputs against the model, apply the spec rules for the
  // coming edge, then wait until just after that edge.
  task automatic step();
    int  old_sz;
    int  old_st;
    bit  ready;
    bit  push;
    bit  bnd;
    bit  ur;
    @(negedge clk);
    chk("ready",  32'(SampleReady),   32'(m_st != 0 && m_q.size() < FD));
    chk("level",  32'(FifoLevel),     m_q.size());
    chk("duty",   32'(DutyOut),       32'(m_duty));
    chk("pstart", 32'(PeriodStart),   32'(m_ps));
    chk("urun",   32'(Underrun),      32'(m_ur));
    chk("ucnt",   32'(UnderrunCount), m_ucnt);
    old_sz = m_q.size();
    old_st = m_st;
    ready  = (m_st != 0) && (old_sz < FD);
    push   = SampleValid && ready;
    bnd    = (m_st == 2) && (m_cnt == PERIOD - 1);
    ur     = 1'b0;
    if (bnd) begin
      if (OverrideEn) m_duty = OverrideDuty;
      else if (old_sz > 0) m_duty = m_q.pop_front() ^ MID;
      else begin
        ur = 1'b1;
        if (m_ucnt < 255) m_ucnt++;
        if (!HoldLast) m_duty = MID;
      end
      exp_q.push_back({ur, m_duty});
    end else if (m_st != 2 || !Enable) begin
      m_duty = MID;
    end
    if (push) begin
      m_q.push_back(SampleIn);
      void'(src_q.pop_front());
    end
    if (!Enable) m_q.delete();
    m_ps = bnd;
    m_ur = ur;
    case (old_st)
      0: if (Enable) m_st = 1;
      1: if (!Enable) m_st = 0; else if (old_sz >= PL || OverrideEn) m_st = 2;
      default: if (!Enable) m_st = 0;
    endcase
    m_cnt = (old_st == 2 && Enable) ? (m_cnt + 1) % PERIOD : 0;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_duty"},   32'(DutyOut),       32'(MID));
    chk({tag, "_pstart"}, 32'(PeriodStart),   0);
    chk({tag, "_urun"},   32'(Underrun),      0);
    chk({tag, "_ucnt"},   32'(UnderrunCount), 0);
    chk({tag, "_level"},  32'(FifoLevel),     0);
    chk({tag, "_ready"},  32'(SampleReady),   0);
  endtask

  // Scoreboard monitor: each period strobe consumes one expected duty word.
  always @(negedge clk) begin
    if (rst_n && PeriodStart) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_pstart: got strobe want none at %0t", $time);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_duty",  32'(DutyOut),  32'(sb_e[DW-1:0]));
        chk("sb_urun",  32'(Underrun), 32'(sb_e[DW]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_vals("reset");
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Prime with two samples, then run dry with midscale underruns.
    Enable = 1'b1;
    src_q.push_back(10'h000);
    src_q.push_back(10'h1FF);
    drive();
    repeat (60) step();

    // Continuous alternating stream, FIFO fills and backpressures.
    for (int i = 0; i < 40; i++) begin
      src_q.push_back(10'h200);
      src_q.push_back(10'h1FF);
    end
    drive();
    repeat (200) step();
    src_q.delete();
    drive();

    // Starve until the underrun counter saturates.
    HoldLast = 1'b0;
    repeat (270 * PERIOD) step();
    chk("ucnt_saturated", 32'(UnderrunCount), 255);

    // Hold-last underrun policy keeps a non-midscale word.
    HoldLast = 1'b1;
    src_q.push_back(10'h0FF);
    drive();
    repeat (64) step();

    // Override raised mid-period; stream keeps filling the unpopped FIFO.
    for (int g = 0; g < 40 && m_cnt != 5; g++) step();
    chk("wait_mid_period", 32'(m_cnt == 5), 1);
    OverrideDuty = 10'h0AB;
    OverrideEn   = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back(10'($urandom));
    drive();
    repeat (48) step();
    chk("override_level_full", 32'(FifoLevel), FD);
    OverrideEn = 1'b0;
    src_q.delete();
    drive();

    // Push exactly on the boundary edge with an empty FIFO.
    HoldLast = 1'b0;
    for (int g = 0; g < 200 && m_q.size() != 0; g++) step();
    chk("wait_drained", 32'(m_q.size()), 0);
    for (int g = 0; g < 40 && m_cnt != PERIOD - 1; g++) step();
    chk("wait_boundary", 32'(m_cnt), PERIOD - 1);
    src_q.push_back(10'h123);
    drive();
    step();
    repeat (20) step();

    // Drop Enable with three samples queued.
    for (int i = 0; i < 3; i++) src_q.push_back(10'($urandom));
    drive();
    for (int g = 0; g < 20 && m_q.size() != 3; g++) step();
    chk("wait_three_queued", 32'(FifoLevel), 3);
    Enable = 1'b0;
    drive();
    step();
    chk("drop_idle_level", 32'(FifoLevel), 0);
    chk("drop_idle_duty",  32'(DutyOut), 32'(MID));
    repeat (20) step();

    // Drop Enable exactly on a boundary cycle.
    Enable = 1'b1;
    for (int i = 0; i < 6; i++) src_q.push_back(10'($urandom));
    drive();
    for (int g = 0; g < 60 && !(m_st == 2 && m_cnt == PERIOD - 1); g++) step();
    chk("wait_run_boundary", 32'(m_st == 2 && m_cnt == PERIOD - 1), 1);
    Enable = 1'b0;
    drive();
    step();
    step();
    chk("bnd_drop_midscale", 32'(DutyOut), 32'(MID));
    repeat (5) step();

    // Randomized traffic, policies and enable/override toggling.
    Enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) valid_pct = $urandom_range(100);
      HoldLast     = 1'($urandom_range(1));
      if ($urandom_range(99) < 3) OverrideEn = !OverrideEn;
      OverrideDuty = 10'($urandom);
      if (Enable && $urandom_range(199) == 0) Enable = 1'b0;
      else if (!Enable && $urandom_range(9) == 0) Enable = 1'b1;
      while (src_q.size() < 3) src_q.push_back(10'($urandom));
      drive();
      step();
    end

    // Asynchronous reset in the middle of a period.
    OverrideEn = 1'b0;
    valid_pct  = 100;
    Enable     = 1'b1;
    for (int g = 0; g < 300 && !(m_st == 2 && m_cnt == 7); g++) step();
    chk("wait_mid_run", 32'(m_st == 2 && m_cnt == 7), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    Enable = 1'b0;
    src_q.delete();
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    Enable = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(10'($urandom));
    drive();
    repeat (60) step();

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
